// File: rtl/ped_crossing_ctrl.sv
// ---------------------------------------------------------------------------
// ped_crossing_ctrl
//   Pedestrian-side controller for a signalised crossing. The raw walk button
//   is synchronised and debounced. A debounced press asks the traffic_light
//   block for a crossing with a one-cycle `pass` pulse. The controller then
//   waits for the red phase and drives solid WALK, then flashing DONT_WALK,
//   then a cooldown lockout.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   btn        in   raw pedestrian button (asynchronous, bouncy)
//   R, G, Y    in   lamp outputs of traffic_light (same clock domain)
//   pass       out  one-cycle crossing request to traffic_light
//   walk       out  WALK lamp
//   dont_walk  out  DONT_WALK lamp (solid or flashing)
//   req_led    out  request-accepted indicator
//   err        out  one-cycle pulse on red timeout or illegal lamp code
// ---------------------------------------------------------------------------
module ped_crossing_ctrl #(
  parameter int DB_CYC       = 16,
  parameter int WALK_CYC     = 256,
  parameter int FLASH_CYC    = 128,
  parameter int FLASH_HALF   = 16,
  parameter int COOLDOWN_CYC = 512,
  parameter int RED_TO       = 4095,
  parameter int CNT_W        = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic R,
  input  logic G,
  input  logic Y,
  output logic pass,
  output logic walk,
  output logic dont_walk,
  output logic req_led,
  output logic err
);

  // Terminal values: a phase of N cycles ends when the counter, reloaded to
  // zero on entry, is seen at N-1.
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYC - 1);
  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYC - 1);
  localparam logic [CNT_W-1:0] HALF       = CNT_W'(FLASH_HALF);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN_CYC - 1);
  localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(RED_TO - 1);

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    WAIT_R,
    WALK,
    FLASH,
    COOLDOWN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             latched;

  logic             btn_sync_p0;
  logic             btn_sync_p1;
  logic             btn_db;
  logic             btn_db_q;
  logic [CNT_W-1:0] db_cnt;
  logic             press;
  logic             illegal;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // More than one lamp lit at once is never a legal traffic_light output.
  function automatic logic lamp_illegal(input logic r, input logic g, input logic y);
    return (r & g) | (r & y) | (g & y);
  endfunction

  assign illegal = lamp_illegal(R, G, Y);
  assign press   = btn_db & ~btn_db_q;

  // Stage p0/p1: two-flop synchroniser, then the debouncer. The debounced
  // level flips only after DB_CYC consecutive cycles of disagreement; any
  // agreeing cycle restarts the count, so bounce pulses are absorbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_sync_p0 <= 1'b0;
      btn_sync_p1 <= 1'b0;
      btn_db      <= 1'b0;
      btn_db_q    <= 1'b0;
      db_cnt      <= '0;
    end else begin
      btn_sync_p0 <= btn;
      btn_sync_p1 <= btn_sync_p0;
      btn_db_q    <= btn_db;
      if (btn_sync_p1 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt >= DB_LAST) begin
        btn_db <= btn_sync_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= sat_inc(db_cnt);
      end
    end
  end

  // Crossing FSM with registered outputs. pass and err are single-cycle
  // pulses and default low every cycle. One shared counter times every
  // phase and is reloaded to zero on each state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      latched   <= 1'b0;
      pass      <= 1'b0;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      req_led   <= 1'b0;
      err       <= 1'b0;
    end else begin
      pass <= 1'b0;
      err  <= 1'b0;
      if (illegal) begin
        // A corrupted lamp code overrides every transition and drops any request.
        state     <= IDLE;
        cnt       <= '0;
        latched   <= 1'b0;
        walk      <= 1'b0;
        dont_walk <= 1'b1;
        req_led   <= 1'b0;
        err       <= 1'b1;
      end else begin
        cnt <= sat_inc(cnt);
        unique case (state)
          IDLE: begin
            if (press) begin
              state   <= PEND;
              cnt     <= '0;
              req_led <= 1'b1;
            end
          end
          PEND: begin
            // Request only while the vehicles have green.
            if (G) begin
              pass  <= 1'b1;
              state <= WAIT_R;
              cnt   <= '0;
            end
          end
          WAIT_R: begin
            if (R) begin
              state     <= WALK;
              cnt       <= '0;
              walk      <= 1'b1;
              dont_walk <= 1'b0;
              req_led   <= 1'b0;
            end else if (cnt >= RED_LAST) begin
              state   <= IDLE;
              cnt     <= '0;
              req_led <= 1'b0;
              err     <= 1'b1;
            end
          end
          WALK: begin
            // Loss of red ends the crossing at once, so walk falls on the
            // same edge that sees R low.
            if (!R) begin
              state     <= COOLDOWN;
              cnt       <= '0;
              walk      <= 1'b0;
              dont_walk <= 1'b1;
            end else if (cnt >= WALK_LAST) begin
              state     <= FLASH;
              cnt       <= '0;
              walk      <= 1'b0;
              dont_walk <= 1'b1;
            end
          end
          FLASH: begin
            if (!R || cnt >= FLASH_LAST) begin
              state     <= COOLDOWN;
              cnt       <= '0;
              dont_walk <= 1'b1;
            end else if ((cnt % HALF) == HALF_LAST) begin
              dont_walk <= ~dont_walk;
            end
          end
          COOLDOWN: begin
            // A press here is remembered and served once the lockout ends.
            if (press) begin
              latched <= 1'b1;
              req_led <= 1'b1;
            end
            if (cnt >= COOL_LAST) begin
              cnt     <= '0;
              latched <= 1'b0;
              if (latched || press) begin
                state   <= PEND;
                req_led <= 1'b1;
              end else begin
                state   <= IDLE;
                req_led <= 1'b0;
              end
            end
          end
          default: begin
            state     <= IDLE;
            cnt       <= '0;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ped_crossing_ctrl
//   Scenario bench for ped_crossing_ctrl. Expected event cycles and lengths
//   are pushed to a queue when stimulus is applied, then popped and compared
//   when the DUT produces the corresponding output.
// ---------------------------------------------------------------------------
module tb_ped_crossing_ctrl;

  localparam int DB_CYC       = 16;
  localparam int WALK_CYC     = 256;
  localparam int FLASH_CYC    = 128;
  localparam int FLASH_HALF   = 16;
  localparam int COOLDOWN_CYC = 512;
  localparam int RED_TO       = 4095;
  localparam int CNT_W        = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic R   = 1'b0;
  logic G   = 1'b0;
  logic Y   = 1'b0;
  logic pass, walk, dont_walk, req_led, err;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  ped_crossing_ctrl #(
    .DB_CYC      (DB_CYC),
    .WALK_CYC    (WALK_CYC),
    .FLASH_CYC   (FLASH_CYC),
    .FLASH_HALF  (FLASH_HALF),
    .COOLDOWN_CYC(COOLDOWN_CYC),
    .RED_TO      (RED_TO),
    .CNT_W       (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .R        (R),
    .G        (G),
    .Y        (Y),
    .pass     (pass),
    .walk     (walk),
    .dont_walk(dont_walk),
    .req_led  (req_led),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return pass;
      1:       return walk;
      2:       return err;
      3:       return req_led;
      default: return 1'b0;
    endcase
  endfunction

  // Steps until the selected output is high; at = -1 if the budget runs out.
  task automatic wait_high(input int which, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (sig_of(which)) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 1'b0; R = 1'b0; G = 1'b0; Y = 1'b0;
    repeat (3) step();
    checks++; if (pass !== 1'b0)      begin failures++; $display("FAIL reset_pass got=%b want=0", pass); end
    checks++; if (walk !== 1'b0)      begin failures++; $display("FAIL reset_walk got=%b want=0", walk); end
    checks++; if (dont_walk !== 1'b1) begin failures++; $display("FAIL reset_dont_walk got=%b want=1", dont_walk); end
    checks++; if (req_led !== 1'b0)   begin failures++; $display("FAIL reset_req_led got=%b want=0", req_led); end
    checks++; if (err !== 1'b0)       begin failures++; $display("FAIL reset_err got=%b want=0", err); end
    rst = 1'b0;
    repeat (2) step();
  endtask

  // Bouncy press with G already lit: press accepted after sync + debounce,
  // then exactly one pass pulse.
  task automatic test_debounce_pass(output int p);
    int c0, at, expv;
    G = 1'b1; R = 1'b0; Y = 1'b0;
    step();
    btn = 1'b1; step();
    btn = 1'b0; step();
    btn = 1'b1; step();
    btn = 1'b0; step();
    btn = 1'b1; c0 = cyc;
    exp_q.push_back(c0 + DB_CYC + 3);
    exp_q.push_back(c0 + DB_CYC + 4);
    checks++; if (req_led !== 1'b0) begin failures++; $display("FAIL db_req_led_early got=%b want=0", req_led); end
    wait_high(3, 60, at);
    expv = exp_q.pop_front();
    checks++; if (at !== expv) begin failures++; $display("FAIL db_req_led_cycle got=%0d want=%0d", at, expv); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL db_pass_early got=%b want=0", pass); end
    wait_high(0, 10, at);
    expv = exp_q.pop_front();
    checks++; if (at !== expv) begin failures++; $display("FAIL db_pass_cycle got=%0d want=%0d", at, expv); end
    p = at;
    step();
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL db_pass_width got=%b want=0", pass); end
  endtask

  // R arrives 2047 cycles after pass: 256 WALK, 128 flashing, 512 solid.
  task automatic test_walk_flash(input int p);
    int at, expv, wlen, bad;
    logic dw_exp;
    step_to(p + 2046);
    G = 1'b0; R = 1'b1;
    exp_q.push_back(p + 2047);
    exp_q.push_back(WALK_CYC);
    wait_high(1, 10, at);
    expv = exp_q.pop_front();
    checks++; if (at !== expv) begin failures++; $display("FAIL walk_start got=%0d want=%0d", at, expv); end
    wlen = (walk === 1'b1) ? 1 : 0;
    bad  = (dont_walk !== 1'b0) ? 1 : 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (walk !== 1'b1) break;
      wlen++;
      if (dont_walk !== 1'b0) bad++;
    end
    expv = exp_q.pop_front();
    checks++; if (wlen !== expv) begin failures++; $display("FAIL walk_length got=%0d want=%0d", wlen, expv); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL walk_dont_walk_low bad_cycles=%0d want=0", bad); end
    bad = 0;
    for (int k = 0; k < FLASH_CYC; k++) begin
      dw_exp = (((k / FLASH_HALF) % 2) == 0);
      if (dont_walk !== dw_exp || walk !== 1'b0) begin
        if (bad == 0) $display("FAIL flash_pattern k=%0d got dw=%b walk=%b want dw=%b walk=0", k, dont_walk, walk, dw_exp);
        bad++;
      end
      step();
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL flash_total bad_cycles=%0d want=0", bad); end
    bad = 0;
    for (int k = 0; k < COOLDOWN_CYC; k++) begin
      if (dont_walk !== 1'b1 || walk !== 1'b0 || pass !== 1'b0) bad++;
      step();
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL cooldown_solid bad_cycles=%0d want=0", bad); end
  endtask

  // Press during yellow; pass must wait for G and fire the cycle after.
  task automatic test_pend_wait_g(output int p);
    int b, g, at, expv, bad;
    btn = 1'b0; R = 1'b0; G = 1'b0; Y = 1'b1;
    repeat (30) step();
    btn = 1'b1; b = cyc;
    exp_q.push_back(b + DB_CYC + 3);
    wait_high(3, 60, at);
    expv = exp_q.pop_front();
    checks++; if (at !== expv) begin failures++; $display("FAIL pend_req_led got=%0d want=%0d", at, expv); end
    bad = 0;
    repeat (300) begin
      step();
      if (pass !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL pend_pass_before_g count=%0d want=0", bad); end
    G = 1'b1; Y = 1'b0; g = cyc;
    exp_q.push_back(g + 1);
    wait_high(0, 10, at);
    expv = exp_q.pop_front();
    checks++; if (at !== expv) begin failures++; $display("FAIL pend_pass_cycle got=%0d want=%0d", at, expv); end
    p = at;
  endtask

  // R never comes: err pulse after RED_TO cycles, back to IDLE.
  task automatic test_red_timeout(input int p);
    int at, expv, bad;
    exp_q.push_back(p + RED_TO);
    wait_high(2, RED_TO + 100, at);
    expv = exp_q.pop_front();
    checks++; if (at !== expv) begin failures++; $display("FAIL timeout_err_cycle got=%0d want=%0d", at, expv); end
    checks++; if (req_led !== 1'b0) begin failures++; $display("FAIL timeout_req_led got=%b want=0", req_led); end
    checks++; if (walk !== 1'b0 || dont_walk !== 1'b1) begin failures++; $display("FAIL timeout_lamps got walk=%b dw=%b want walk=0 dw=1", walk, dont_walk); end
    step();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL timeout_err_width got=%b want=0", err); end
    bad = 0;
    repeat (20) begin
      step();
      if (pass !== 1'b0 || walk !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL timeout_idle count=%0d want=0", bad); end
  endtask

  // R drops 100 cycles into WALK; press in cooldown is served afterwards.
  task automatic test_early_drop_cooldown(output int p2);
    int b, p, w, c, at, expv;
    btn = 1'b0; G = 1'b1; R = 1'b0; Y = 1'b0;
    repeat (30) step();
    btn = 1'b1; b = cyc;
    exp_q.push_back(b + DB_CYC + 4);
    wait_high(0, 60, at);
    expv = exp_q.pop_front();
    checks++; if (at !== expv) begin failures++; $display("FAIL drop_pass_cycle got=%0d want=%0d", at, expv); end
    p = at;
    R = 1'b1; G = 1'b0; btn = 1'b0;
    exp_q.push_back(p + 1);
    wait_high(1, 5, at);
    expv = exp_q.pop_front();
    checks++; if (at !== expv) begin failures++; $display("FAIL drop_walk_start got=%0d want=%0d", at, expv); end
    w = at;
    step_to(w + 99);
    checks++; if (walk !== 1'b1) begin failures++; $display("FAIL drop_walk_held got=%b want=1", walk); end
    R = 1'b0;
    step();
    checks++; if (walk !== 1'b0 || dont_walk !== 1'b1) begin failures++; $display("FAIL drop_lamps got walk=%b dw=%b want walk=0 dw=1", walk, dont_walk); end
    c = cyc;
    G = 1'b1;
    step_to(c + 10);
    btn = 1'b1;
    step_to(c + 100);
    checks++; if (req_led !== 1'b1) begin failures++; $display("FAIL drop_latched_req_led got=%b want=1", req_led); end
    exp_q.push_back(c + COOLDOWN_CYC + 1);
    wait_high(0, COOLDOWN_CYC + 100, at);
    expv = exp_q.pop_front();
    checks++; if (at !== expv) begin failures++; $display("FAIL drop_pass_after_cooldown got=%0d want=%0d", at, expv); end
    p2 = at;
  endtask

  // Asynchronous reset mid-WALK, then an illegal lamp code in PEND.
  task automatic test_reset_and_illegal(input int p);
    int at, expv, b, x, bad;
    R = 1'b1; G = 1'b0;
    exp_q.push_back(p + 1);
    wait_high(1, 5, at);
    expv = exp_q.pop_front();
    checks++; if (at !== expv) begin failures++; $display("FAIL rst_walk_start got=%0d want=%0d", at, expv); end
    repeat (50) step();
    btn = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (walk !== 1'b0)      begin failures++; $display("FAIL async_rst_walk got=%b want=0", walk); end
    checks++; if (dont_walk !== 1'b1) begin failures++; $display("FAIL async_rst_dont_walk got=%b want=1", dont_walk); end
    checks++; if (req_led !== 1'b0 || pass !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL async_rst_other got req=%b pass=%b err=%b want 0 0 0", req_led, pass, err); end
    repeat (2) step();
    rst = 1'b0;
    bad = 0;
    repeat (30) begin
      step();
      if (walk !== 1'b0 || pass !== 1'b0 || req_led !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL post_rst_idle count=%0d want=0", bad); end
    R = 1'b0; G = 1'b0; Y = 1'b1;
    btn = 1'b1; b = cyc;
    exp_q.push_back(b + DB_CYC + 3);
    wait_high(3, 60, at);
    expv = exp_q.pop_front();
    checks++; if (at !== expv) begin failures++; $display("FAIL illegal_pend_entry got=%0d want=%0d", at, expv); end
    R = 1'b1; G = 1'b1; Y = 1'b0; x = cyc;
    exp_q.push_back(x + 1);
    wait_high(2, 5, at);
    expv = exp_q.pop_front();
    checks++; if (at !== expv) begin failures++; $display("FAIL illegal_err_cycle got=%0d want=%0d", at, expv); end
    R = 1'b0; G = 1'b1;
    checks++; if (pass !== 1'b0 || req_led !== 1'b0) begin failures++; $display("FAIL illegal_override got pass=%b req=%b want 0 0", pass, req_led); end
    checks++; if (walk !== 1'b0 || dont_walk !== 1'b1) begin failures++; $display("FAIL illegal_lamps got walk=%b dw=%b want walk=0 dw=1", walk, dont_walk); end
    step();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL illegal_err_width got=%b want=0", err); end
    bad = 0;
    repeat (20) begin
      step();
      if (pass !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL illegal_back_to_idle count=%0d want=0", bad); end
  endtask

  initial begin
    int p;
    test_reset();
    test_debounce_pass(p);
    test_walk_flash(p);
    test_pend_wait_g(p);
    test_red_timeout(p);
    test_early_drop_cooldown(p);
    test_reset_and_illegal(p);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
